// File: rtl/add8_block_acc_pkg.sv
// Shared definitions for the block accumulator: carry-chain LUT programming,
// FSM state encoding and a behavioural model of the LUT6_2 primitive.
package add8_block_acc_pkg;

  // Upper half (O6) is I0^I1, lower half (O5) passes I0 through to MUXCY.DI.
  localparam logic [63:0] ADD_LUT_INIT = 64'h66666666AAAAAAAA;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  // Returns {O6, O5}. O5 reads the lower 32 INIT bits, so address bit 5 is ignored.
  function automatic logic [1:0] lut6_2(input logic [63:0] init,
                                        input logic [5:0]  addr);
    return {init[addr], init[{1'b0, addr[4:0]}]};
  endfunction

endpackage

// File: rtl/add_cy.sv
// Combinational ripple adder built from one LUT6_2/MUXCY/XORCY slice per bit.
module add_cy
  import add8_block_acc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  output logic [WIDTH-1:0] O,
  output logic             COUT
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar k = 0; k < WIDTH; k++) begin : g_bit
    logic o6;
    logic o5;

    // I5 tied high selects the XOR half for O6; I2-I4 tied low.
    assign {o6, o5}     = lut6_2(ADD_LUT_INIT, {1'b1, 3'b000, I1[k], I0[k]});
    assign carry[k + 1] = o6 ? carry[k] : o5;
    assign O[k]         = o6 ^ carry[k];
  end

  assign COUT = carry[WIDTH];

endmodule

// File: rtl/add8_block_acc.sv
// Sums N consecutive accepted samples and presents the block sum with a
// sticky MSB carry flag, using valid/ready handshakes on both sides.
module add8_block_acc
  import add8_block_acc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             CLR,
  input  logic [WIDTH-1:0] I,
  input  logic             I_VALID,
  output logic             I_READY,
  output logic [WIDTH-1:0] O,
  output logic             COUT,
  output logic             O_VALID,
  input  logic             O_READY
);

  localparam int                CNT_W    = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_next;
  logic [WIDTH-1:0] acc, acc_next_q;
  logic             cov, cov_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  logic [WIDTH-1:0] sum;
  logic             co;
  logic             accept;

  add_cy #(.WIDTH(WIDTH)) u_add_cy (
    .I0  (acc),
    .I1  (I),
    .O   (sum),
    .COUT(co)
  );

  // Handshake outputs depend on registered state only.
  assign I_READY = (state == ACC);
  assign O_VALID = (state == DONE);
  assign O       = acc;
  assign COUT    = cov;
  assign accept  = I_VALID && I_READY;

  // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    acc_next_q = acc;
    cov_next   = cov;
    cnt_next   = cnt;

    unique case (state)
      ACC: begin
        if (accept) begin
          acc_next_q = sum;
          cov_next   = cov | co;
          if (cnt == CNT_LAST) begin
            cnt_next   = '0;
            state_next = DONE;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
      end
      DONE: begin
        if (O_READY) begin
          acc_next_q = '0;
          cov_next   = 1'b0;
          state_next = ACC;
        end
      end
      default: state_next = ACC;
    endcase

    // Abort wins over any accept or output handshake in the same cycle.
    if (CLR) begin
      acc_next_q = '0;
      cov_next   = 1'b0;
      cnt_next   = '0;
      state_next = ACC;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= ACC;
      acc   <= '0;
      cov   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next_q;
      cov   <= cov_next;
      cnt   <= cnt_next;
    end
  end

endmodule

// File: doc/add8_block_acc.md
# add8_block_acc

Registered block accumulator that sums `N` consecutive input samples on the Spartan-6 carry chain (LUT6_2 + MUXCY + XORCY per bit) and presents the block sum with a carry/overflow flag. It is the additive counterpart of the subtract datapath: the same primitive chain, with the LUT programmed for addition instead of subtraction. It sits between a streaming sample source and any consumer that needs windowed sums, with valid/ready flow control on both sides.

## Interface
- `WIDTH`, 8: bits per sample and per sum; one LUT6_2/MUXCY/XORCY slice per bit.
- `N`, 4: samples per block; must be at least 2. The sample counter is `$clog2(N)` bits wide.
- `CLK` input 1: single clock, rising edge.
- `RESETN` input 1: reset, asynchronous and active-low.
- `CLR` input 1: synchronous abort of the current block.
- `I` input WIDTH: sample data.
- `I_VALID` input 1: sample offered.
- `I_READY` output 1: block can accept a sample.
- `O` output WIDTH: block sum, modulo 2^WIDTH.
- `COUT` output 1: sticky carry-out of the MSB for the block.
- `O_VALID` output 1: `O` and `COUT` hold a completed block.
- `O_READY` input 1: consumer takes the block.

## Operation
- Datapath: `acc_next = acc + I`. Each bit uses one LUT6_2, INIT 64'h66666666AAAAAAAA.
  - LUT inputs: I0 = acc[k], I1 = I[k], I2–I4 tied 0, I5 tied 1.
  - O6 = acc[k]^I[k] drives MUXCY.S and XORCY.LI.
  - O5 = acc[k] drives MUXCY.DI.
  - Bit 0 carry-in is 1'b0. Carry ripples MUXCY_k.O to slice k+1. The top MUXCY.O is the carry-out `co`.
- States: ACC and DONE. The encoding lives in the shared package.
- ACC:
  - `I_READY`=1, `O_VALID`=0.
  - On accept (`I_VALID & I_READY`): `acc<=acc_next`, `cov<=cov|co`, `cnt<=cnt+1`.
  - The accept where `cnt==N-1` moves to DONE, with `cnt<=0`.
- DONE:
  - `I_READY`=0, `O_VALID`=1; `O`=acc and `COUT`=cov, held stable.
  - On `O_READY`: `acc<=0`, `cov<=0`, go to ACC.
- `CLR` (synchronous, in any state):
  - Sets `acc=0`, `cov=0`, `cnt=0`, state ACC.
  - Overrides any same-cycle accept or output handshake; the discarded block is never presented.
- Wrap-around: the sum is modulo 2^WIDTH. Any MSB carry within the block sets `COUT` to 1 for that block.
- `RESETN` low at any time, including mid-block or while DONE:
  - Immediately (asynchronously) sets `acc=0`, `cov=0`, `cnt=0`, state ACC.
  - Outputs: `O`=0, `COUT`=0, `O_VALID`=0, `I_READY`=1.
  - After deassertion, the first rising edge may accept a sample.

## Timing
- `I_READY` and `O_VALID` are decoded from registered state only; they have no combinational path from `I_VALID`, `O_READY` or `CLR`.
- Latency: `O_VALID` rises on the edge that accepts the N-th sample. `O` equals the complete sum in that same cycle.
- Throughput: N accept cycles plus at least 1 DONE cycle per block. With `O_READY` tied high, the steady state is one block per N+1 cycles.
- Backpressure: while `O_READY`=0 in DONE, `O`, `COUT` and `O_VALID` hold indefinitely and no input is accepted.
- Gaps: `I_VALID`=0 cycles in ACC leave `acc`, `cov` and `cnt` unchanged.
- Carry-chain critical path: one LUT plus WIDTH MUXCY stages plus XORCY, into the `acc` flops.

## Structure
- Package `add8_block_acc_pkg`:
  - Constant `ADD_LUT_INIT` = 64'h66666666AAAAAAAA.
  - State typedef (ACC, DONE).
- Sub-module `add_cy`: parameterised WIDTH, combinational carry-chain adder built from LUT6_2/MUXCY/XORCY.
  - Ports `I0`, `I1`, `O`, `COUT`.
  - Instantiated once; the wrapper holds the state, counter and registers.

## Test plan
- Reset then N=4 block: samples 10, 20, 30, 40 with `O_READY`=1 → `O_VALID`=1 on the 4th accept edge, `O`=100, `COUT`=0. The next cycle has `O_VALID`=0 and `I_READY`=1.
- Overflow: samples 200, 100, 0, 0 → `O`=44, `COUT`=1. The following block of 1, 1, 1, 1 gives `O`=4, `COUT`=0 (sticky flag cleared).
- Backpressure: hold `O_READY`=0 for 3 cycles in DONE while `I_VALID`=1 with 0x55 → `O` stable, `I_READY`=0, nothing accepted. Raising `O_READY` returns to ACC with `acc`=0.
- Gaps and CLR: 5 (accept), idle 2 cycles, 7 (accept), then `CLR`=1 together with `I_VALID`=1, `I`=9 → 9 discarded, `cnt`=0. The next block 1, 2, 3, 4 gives `O`=10.
- Async reset mid-block: after 2 accepts, pulse `RESETN` low between clock edges → outputs `O`=0, `COUT`=0, `O_VALID`=0, `I_READY`=1 without waiting for a clock edge. The next full block sums correctly.
- Exhaustive carry chain: for `WIDTH`=8, a random plus corner sweep (0xFF+0x01, 0x80+0x80, 0x7F+0x01) compared against a behavioural `acc+I` model, checking both sum and carry.
